grey_hist_eq: RTL



---
 rtl/grey_hist_eq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/grey_hist_eq.sv
// Histogram-equalisation stage: accumulates a 256-bin grey histogram, builds a CDF LUT during blanking, maps pixels through it.
// Optional macro GREY_EQ_IDENTITY_INIT_EN: CLEAR loads an identity LUT ({bin, 4'h0}) instead of zeros.
module grey_hist_eq #(
    parameter int unsigned NPIX = 307200,
    parameter int unsigned MULT = 32'((64'd4095 * 64'd1048576 + 64'(NPIX / 2)) / 64'(NPIX))
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [11:0] iGREY,
    input  logic        iDVAL,
    input  logic        iFRAME_DONE,
    input  logic        iEQ_EN,
    output logic [11:0] oGREY,
    output logic        oDVAL,
    output logic        oBUSY
);
    localparam int unsigned GREY_W = 12;
    localparam int unsigned BIN_W  = 8;
    localparam int unsigned CNT_W  = 19;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned MULT_W = $clog2(MULT + 1);
    localparam int unsigned PROD_W = CNT_W + MULT_W;
    localparam int unsigned FRAC_W = 20;

    typedef enum logic [1:0] {CLEAR, ACCUM, BUILD} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;

    logic [CNT_W-1:0]   hist [256];
    logic [GREY_W-1:0]  lut  [256];

    logic [CNT_W-1:0]   rd_data;
    logic               s1_inc, s1_clr;
    logic [BIN_W-1:0]   s1_bin;
    logic               w_vld;
    logic [BIN_W-1:0]   w_bin;
    logic [CNT_W-1:0]   w_data;
    logic [CNT_W-1:0]   cdf;
    logic               l_vld;
    logic [BIN_W-1:0]   l_idx;
    logic [GREY_W-1:0]  lut_rd, p_grey;
    logic               p_en, p_vld;

    logic [BIN_W-1:0]   rd_addr;
    logic [CNT_W-1:0]   base, base_inc, cdf_nxt;
    logic [CNT_W:0]     cdf_sum;
    logic [PROD_W-1:0]  prod, prod_sh;
    logic [GREY_W-1:0]  scaled, lut_init;
    logic               hist_we, lut_we;
    logic [BIN_W-1:0]   hist_wa, lut_wa;
    logic [CNT_W-1:0]   hist_wd;
    logic [GREY_W-1:0]  lut_wd;

    // State register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next state: CLEAR sweeps 256 entries, BUILD sweeps 256 reads plus 2 drain cycles
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx + IDX_W'(1);
        case (state)
            CLEAR: begin
                if (idx == IDX_W'(255)) begin
                    state_nxt = ACCUM;
                    idx_nxt   = '0;
                end
            end
            ACCUM: begin
                idx_nxt = '0;
                if (iFRAME_DONE) state_nxt = BUILD;
            end
            BUILD: begin
                if (idx == IDX_W'(257)) begin
                    state_nxt = ACCUM;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                idx_nxt   = '0;
            end
        endcase
    end

    // Histogram read/modify/write with one-deep forwarding of the previous write
    always_comb begin
        rd_addr  = (state == BUILD) ? idx[BIN_W-1:0] : iGREY[11:4];
        base     = (w_vld && (w_bin == s1_bin)) ? w_data : rd_data;
        base_inc = (&base) ? base : base + CNT_W'(1);
        cdf_sum  = {1'b0, cdf} + {1'b0, base};
        cdf_nxt  = cdf_sum[CNT_W] ? '1 : cdf_sum[CNT_W-1:0];
        prod     = PROD_W'(cdf) * PROD_W'(MULT);
        prod_sh  = prod >> FRAC_W;
        scaled   = (prod_sh > PROD_W'(4095)) ? '1 : GREY_W'(prod_sh);
`ifdef GREY_EQ_IDENTITY_INIT_EN
        lut_init = {idx[BIN_W-1:0], 4'h0};
`else
        lut_init = '0;
`endif
        hist_we = 1'b0;
        hist_wa = s1_bin;
        hist_wd = '0;
        lut_we  = 1'b0;
        lut_wa  = l_idx;
        lut_wd  = scaled;
        if (state == CLEAR) begin
            hist_we = 1'b1;
            hist_wa = idx[BIN_W-1:0];
            lut_we  = 1'b1;
            lut_wa  = idx[BIN_W-1:0];
            lut_wd  = lut_init;
        end else begin
            if (s1_inc) begin
                hist_we = 1'b1;
                hist_wd = base_inc;
            end else if (s1_clr) begin
                hist_we = 1'b1;
            end
            lut_we = l_vld;
        end
    end

    // Histogram and LUT storage
    always_ff @(posedge iCLK) begin
        rd_data <= hist[rd_addr];
        lut_rd  <= lut[iGREY[11:4]];
        if (hist_we && !iRST) hist[hist_wa] <= hist_wd;
        if (lut_we && !iRST)  lut[lut_wa]   <= lut_wd;
    end

    // Pipeline registers and outputs
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1_inc <= 1'b0;
            s1_clr <= 1'b0;
            s1_bin <= '0;
            w_vld  <= 1'b0;
            w_bin  <= '0;
            w_data <= '0;
            cdf    <= '0;
            l_vld  <= 1'b0;
            l_idx  <= '0;
            p_grey <= '0;
            p_en   <= 1'b0;
            p_vld  <= 1'b0;
            oGREY  <= '0;
            oDVAL  <= 1'b0;
            oBUSY  <= 1'b1;
        end else begin
            s1_inc <= (state == ACCUM) && iDVAL;
            s1_clr <= (state == BUILD) && !idx[IDX_W-1];
            s1_bin <= rd_addr;
            w_vld  <= hist_we;
            w_bin  <= hist_wa;
            w_data <= hist_wd;
            if (state == ACCUM)  cdf <= '0;
            else if (s1_clr)     cdf <= cdf_nxt;
            l_vld  <= s1_clr;
            l_idx  <= s1_bin;
            p_grey <= iGREY;
            p_en   <= iEQ_EN;
            p_vld  <= iDVAL;
            oGREY  <= p_en ? lut_rd : p_grey;
            oDVAL  <= p_vld;
            oBUSY  <= (state_nxt != ACCUM);
        end
    end
endmodule
